// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// State encoding, parameter defaults and a one-hot decode helper.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        LOAD      = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_REQ  = 3'd4
    } state_e;

    localparam int          DEF_NREQ    = 4;
    localparam int          DEF_TO_W    = 20;
    localparam int unsigned DEF_TIMEOUT = 200000;

    function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    function automatic logic [NREQ-1:0] pick(
        input logic [NREQ-1:0]  r,
        input logic [IDX_W-1:0] p
    );
        logic [NREQ-1:0] g;
        int              idx;
        g = '0;
        // Walk offsets downward so the smallest offset from p wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx[IDX_W-1:0]]) begin
                g = '0;
                g[idx[IDX_W-1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

    assign gnt = pick(req, ptr);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler sharing one UART transmitter among NREQ
// byte-stream requesters, with stall timeout supervision.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int              NREQ    = DEF_NREQ,
    parameter int              IDX_W   = $clog2(NREQ),
    parameter int              TO_W    = DEF_TO_W,
    parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEF_TIMEOUT)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NREQ-1:0]   Req,
    input  logic [8*NREQ-1:0] ReqData,
    input  logic [NREQ-1:0]   ReqLast,
    output logic [NREQ-1:0]   Ack,
    output logic [NREQ-1:0]   Grant,
    output logic              TxStart,
    output logic [7:0]        TxData,
    input  logic              TxDone,
    output logic              Busy,
    output logic              TimeoutErr,
    output logic [IDX_W-1:0]  ErrIdx
);

    localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              to_err_q, to_err_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;

    logic [NREQ-1:0]   pick;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  next_ptr;
    logic [TO_W-1:0]   cnt_inc;
    logic              req_g;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (Req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Next-state and registered-output computation for the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        to_err_d   = 1'b0;
        err_idx_d  = err_idx_q;

        owner    = IDX_W'(onehot_to_idx(8'(grant_q)));
        next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        req_g    = |(Req & grant_q);

        unique case (state_q)
            IDLE: begin
                if (|Req) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = LOAD;
            end
            LOAD: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q[i]) begin
                        tx_data_d = ReqData[8*i +: 8];
                    end
                end
                last_d     = |(ReqLast & grant_q);
                ack_d      = grant_q;
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (TxDone) begin
                    if (last_q) begin
                        ptr_d   = next_ptr;
                        grant_d = '0;
                        state_d = IDLE;
                    end else if (req_g) begin
                        state_d = LOAD;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_REQ;
                    end
                end else if (cnt_inc >= TO_LAST) begin
                    to_err_d  = 1'b1;
                    err_idx_d = owner;
                    ptr_d     = next_ptr;
                    grant_d   = '0;
                    state_d   = IDLE;
                end
            end
            WAIT_REQ: begin
                cnt_d = cnt_inc;
                if (req_g) begin
                    state_d = LOAD;
                end else if (cnt_inc >= TO_LAST) begin
                    to_err_d  = 1'b1;
                    err_idx_d = owner;
                    ptr_d     = next_ptr;
                    grant_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            to_err_q   <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            to_err_q   <= to_err_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign Grant      = grant_q;
    assign Ack        = ack_q;
    assign TxStart    = tx_start_q;
    assign TxData     = tx_data_q;
    assign Busy       = (state_q != IDLE);
    assign TimeoutErr = to_err_q;
    assign ErrIdx     = err_idx_q;

endmodule
